mymax_batch_ctrl: RTL and testbench

- Memory-mapped MSP430 peripheral that sequences a batch max-reduction without per-value software handshakes.
- Software pushes values into a 4-entry input FIFO, writes a count and start, then polls status and reads the result.
- An internal FSM pops FIFO entries and folds each popped value into an unsigned running maximum.
- Sits on the MSP430 peripheral bus (per_* signals) beside the existing handshake-driven max peripheral, in a disjoint address window.

---
 rtl/mymax_pkg.sv | 27 ++
 rtl/mymax_fifo.sv | 61 ++++++
 rtl/mymax_batch_ctrl.sv | 128 ++++++++++++
 tb/tb_mymax_batch_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mymax_pkg.sv
// Shared constants and state encoding for the batch max-reduction peripheral.
// Register offsets, CTRL/STATUS bit positions and FSM states.
package mymax_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_CTRL   = 2'd1;
    localparam logic [1:0] REG_RESULT = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int CTRL_START   = 0;
    localparam int CTRL_CLEAR   = 1;
    localparam int CTRL_CNT_LSB = 8;

    localparam int ST_BUSY    = 0;
    localparam int ST_DONE    = 1;
    localparam int ST_FULL    = 2;
    localparam int ST_EMPTY   = 3;
    localparam int ST_OVF     = 4;
    localparam int ST_REM_LSB = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mymax_fifo.sv
// Small synchronous FIFO with flush; a level counter drives full/empty.
// Pointers wrap naturally because DEPTH is a power of two.
module mymax_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             mclk,
    input  logic             puc_rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    lvl;
    logic             do_push;
    logic             do_pop;

    assign full    = (lvl == LW'(DEPTH));
    assign empty   = (lvl == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            lvl    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            lvl    <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                lvl <= lvl + 1'b1;
            else if (do_pop && !do_push)
                lvl <= lvl - 1'b1;
        end
    end

    // Storage carries no reset; the level counter makes stale words unreachable.
    always_ff @(posedge mclk) begin
        if (do_push && !flush)
            mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/mymax_batch_ctrl.sv
// MSP430 peripheral: FIFO-fed batch unsigned max-reduction with
// start/clear control, result and status registers.
module mymax_batch_ctrl
    import mymax_pkg::*;
#(
    parameter logic [13:0] BASE  = 14'hA8,
    parameter int          DEPTH = 4
) (
    input  logic        mclk,
    input  logic        puc_rst_n,
    input  logic [13:0] per_addr,
    input  logic [15:0] per_din,
    input  logic        per_en,
    input  logic [1:0]  per_we,
    output logic [15:0] per_dout
);

    state_t      state;
    logic [15:0] result;
    logic [7:0]  remaining;
    logic        ovf;

    logic [13:0] off;
    logic        in_win;
    logic        wr;
    logic        rd;
    logic        wr_data;
    logic        wr_ctrl;
    logic        rd_result;
    logic        rd_status;
    logic        ctrl_start;
    logic        ctrl_clear;
    logic [7:0]  ctrl_cnt;

    logic        fifo_full;
    logic        fifo_empty;
    logic [15:0] head;
    logic        pop;
    logic [15:0] status;

    assign off    = per_addr - BASE;
    assign in_win = per_en && (off[13:2] == 12'd0);
    assign wr     = in_win && (per_we == 2'b11);
    assign rd     = in_win && (per_we == 2'b00);

    assign wr_data   = wr && (off[1:0] == REG_DATA);
    assign wr_ctrl   = wr && (off[1:0] == REG_CTRL);
    assign rd_result = rd && (off[1:0] == REG_RESULT);
    assign rd_status = rd && (off[1:0] == REG_STATUS);

    assign ctrl_start = wr_ctrl && per_din[CTRL_START];
    assign ctrl_clear = wr_ctrl && per_din[CTRL_CLEAR];
    assign ctrl_cnt   = per_din[CTRL_CNT_LSB +: 8];

    assign pop = (state == RUN) && !fifo_empty;

    mymax_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .mclk      (mclk),
        .puc_rst_n (puc_rst_n),
        .flush     (ctrl_clear),
        .push      (wr_data),
        .pop       (pop),
        .wdata     (per_din),
        .rdata     (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign status = {remaining, 3'b000, ovf, fifo_empty, fifo_full,
                     state == DONE, state == RUN};

    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            state     <= IDLE;
            result    <= '0;
            remaining <= '0;
            ovf       <= 1'b0;
        end else begin
            // Full is sampled this cycle: a concurrent pop does not save the push.
            if (wr_data && fifo_full)
                ovf <= 1'b1;
            if (ctrl_clear) begin
                state     <= IDLE;
                remaining <= '0;
                ovf       <= 1'b0;
            end else begin
                unique case (state)
                    IDLE, DONE: begin
                        if (ctrl_start) begin
                            result <= '0;
                            if (ctrl_cnt != 8'd0) begin
                                remaining <= ctrl_cnt;
                                state     <= RUN;
                            end else begin
                                state <= DONE;
                            end
                        end
                    end
                    RUN: begin
                        if (pop) begin
                            if (head > result)
                                result <= head;
                            remaining <= remaining - 8'd1;
                            if (remaining == 8'd1)
                                state <= DONE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_comb begin
        per_dout = '0;
        if (puc_rst_n) begin
            unique case (1'b1)
                rd_result: per_dout = result;
                rd_status: per_dout = status;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mymax_batch_ctrl.sv
// Bench for mymax_batch_ctrl: bus-level stimulus, queue-based reference
// model and a read monitor that scores RESULT/STATUS reads.
module tb_mymax_batch_ctrl;
    import mymax_pkg::*;

    localparam logic [13:0] BASE  = 14'hA8;
    localparam int          DEPTH = 4;

    localparam logic [13:0] A_DATA = BASE + 14'(REG_DATA);
    localparam logic [13:0] A_CTRL = BASE + 14'(REG_CTRL);
    localparam logic [13:0] A_RES  = BASE + 14'(REG_RESULT);
    localparam logic [13:0] A_STAT = BASE + 14'(REG_STATUS);

    logic        mclk = 1'b0;
    logic        puc_rst_n = 1'b0;
    logic [13:0] per_addr = '0;
    logic [15:0] per_din = '0;
    logic        per_en = 1'b0;
    logic [1:0]  per_we = '0;
    logic [15:0] per_dout;

    always #5 mclk = ~mclk;

    mymax_batch_ctrl #(
        .BASE  (BASE),
        .DEPTH (DEPTH)
    ) dut (
        .mclk      (mclk),
        .puc_rst_n (puc_rst_n),
        .per_addr  (per_addr),
        .per_din   (per_din),
        .per_en    (per_en),
        .per_we    (per_we),
        .per_dout  (per_dout)
    );

    typedef struct {
        logic [13:0] addr;
        logic [15:0] val;
        logic [15:0] mask;
        string       name;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model: spec-level FIFO contents and batch bookkeeping
    logic [15:0] mq[$];
    bit          m_ovf = 0;
    bit          m_run = 0;
    bit          m_done = 0;
    logic [15:0] m_res = '0;
    int          m_pend = 0;

    // Monitor: scores every decoded read against the next expectation
    always @(negedge mclk) begin
        if (puc_rst_n && per_en && per_we == 2'b00) begin
            exp_t e;
            if (expq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_read addr=%h got=%h", per_addr, per_dout);
            end else begin
                e = expq.pop_front();
                if (e.mask != 16'h0) begin
                    checks++;
                    if (per_addr !== e.addr ||
                        (per_dout & e.mask) !== (e.val & e.mask)) begin
                        failures++;
                        $display("FAIL %s addr=%h got=%h exp=%h mask=%h",
                                 e.name, per_addr, per_dout, e.val, e.mask);
                    end
                end
            end
        end
    end

    function automatic void m_consume(input logic [15:0] v);
        if (v > m_res)
            m_res = v;
        m_pend--;
        if (m_pend == 0) begin
            m_run  = 0;
            m_done = 1;
        end
    endfunction

    function automatic logic [15:0] m_status();
        logic [7:0] r;
        r = 8'(m_pend);
        return {r, 3'b000, m_ovf, mq.size() == 0, mq.size() == DEPTH,
                m_done, m_run};
    endfunction

    function automatic void m_reset();
        mq.delete();
        m_ovf  = 0;
        m_run  = 0;
        m_done = 0;
        m_res  = '0;
        m_pend = 0;
    endfunction

    task automatic bus_wr(input logic [13:0] a, input logic [15:0] d,
                          input logic [1:0] we);
        @(posedge mclk);
        #1;
        per_en   = 1'b1;
        per_addr = a;
        per_din  = d;
        per_we   = we;
        @(posedge mclk);
        #1;
        per_en = 1'b0;
        per_we = 2'b00;
    endtask

    task automatic bus_rd(input logic [13:0] a, input logic [15:0] ev,
                          input logic [15:0] m, input string nm,
                          output logic [15:0] v);
        exp_t e;
        e.addr = a;
        e.val  = ev;
        e.mask = m;
        e.name = nm;
        expq.push_back(e);
        @(posedge mclk);
        #1;
        per_en   = 1'b1;
        per_addr = a;
        per_we   = 2'b00;
        @(negedge mclk);
        v = per_dout;
        @(posedge mclk);
        #1;
        per_en = 1'b0;
    endtask

    task automatic push_val(input logic [15:0] v);
        bus_wr(A_DATA, v, 2'b11);
        if (m_run)
            m_consume(v);
        else if (mq.size() < DEPTH)
            mq.push_back(v);
        else
            m_ovf = 1;
    endtask

    task automatic ctrl(input logic [7:0] cnt, input bit start, input bit clear);
        bus_wr(A_CTRL, {cnt, 6'b000000, clear, start}, 2'b11);
        if (clear) begin
            mq.delete();
            m_ovf  = 0;
            m_pend = 0;
            m_run  = 0;
            m_done = 0;
        end else if (start && !m_run) begin
            m_res  = '0;
            m_done = 0;
            m_pend = int'(cnt);
            if (cnt == 8'd0) begin
                m_done = 1;
            end else begin
                m_run = 1;
                while (m_pend > 0 && mq.size() > 0)
                    m_consume(mq.pop_front());
            end
        end
    endtask

    task automatic chk_status(input string nm);
        logic [15:0] v;
        bus_rd(A_STAT, m_status(), 16'hFFFF, nm, v);
    endtask

    task automatic chk_const(input logic [13:0] a, input logic [15:0] ev,
                             input logic [15:0] m, input string nm);
        logic [15:0] v;
        bus_rd(a, ev, m, nm, v);
    endtask

    task automatic wait_done(input string nm);
        logic [15:0] v;
        bit ok;
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            bus_rd(A_STAT, 16'h0, 16'h0, "poll", v);
            if (v[ST_DONE]) begin
                ok = 1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s timeout status=%h", nm, v);
        end
    endtask

    initial begin
        logic [15:0] v1;

        repeat (3) @(posedge mclk);
        #1;
        puc_rst_n = 1'b1;
        m_reset();

        chk_const(A_STAT, 16'h0008, 16'hFFFF, "reset_status");
        chk_const(A_RES, 16'h0000, 16'hFFFF, "reset_result");

        push_val(16'd3);
        push_val(16'd17);
        push_val(16'd9);
        ctrl(8'd3, 1, 0);
        wait_done("basic_done");
        chk_const(A_STAT, 16'h000A, 16'hFFFF, "basic_status");
        chk_const(A_RES, 16'h0011, 16'hFFFF, "basic_result");

        push_val(16'hFFFF);
        push_val(16'h0001);
        ctrl(8'd2, 1, 0);
        wait_done("unsigned_done");
        chk_const(A_RES, 16'hFFFF, 16'hFFFF, "unsigned_result");

        for (int i = 0; i < 5; i++)
            push_val(16'($urandom));
        chk_const(A_STAT, 16'h0014, 16'h0014, "full_ovf");
        chk_status("overflow_status");
        ctrl(8'd4, 1, 0);
        wait_done("overflow_done");
        chk_result_m("overflow_result");
        chk_status("overflow_after");
        ctrl(8'd0, 0, 1);
        chk_const(A_STAT, 16'h0008, 16'hFFFF, "clear_status");

        ctrl(8'd3, 1, 0);
        repeat (5) @(posedge mclk);
        chk_const(A_STAT, 16'h0309, 16'hFFFF, "starved_status");
        push_val(16'd4);
        repeat (2) @(posedge mclk);
        chk_status("starved_rem2");
        push_val(16'd2);
        repeat (2) @(posedge mclk);
        push_val(16'd8);
        wait_done("starved_done");
        chk_const(A_RES, 16'h0008, 16'hFFFF, "starved_result");

        ctrl(8'd0, 1, 0);
        chk_const(A_STAT, 16'h000A, 16'hFFFF, "zero_status");
        chk_const(A_RES, 16'h0000, 16'hFFFF, "zero_result");

        v1 = 16'($urandom_range(1, 65535));
        ctrl(8'd3, 1, 0);
        push_val(v1);
        chk_status("run_rem2");
        ctrl(8'd7, 1, 0);
        chk_const(A_STAT, 16'h0209, 16'hFFFF, "start_in_run");
        ctrl(8'd0, 1, 1);
        chk_const(A_STAT, 16'h0008, 16'hFFFF, "clear_in_run");
        chk_const(A_RES, v1, 16'hFFFF, "clear_keeps_result");

        bus_wr(A_DATA, 16'hEEEE, 2'b01);
        bus_wr(A_DATA, 16'hEEEE, 2'b10);
        bus_wr(BASE + 14'd4, 16'hEEEE, 2'b11);
        bus_wr(BASE - 14'd1, 16'hEEEE, 2'b11);
        chk_const(A_STAT, 16'h0008, 16'hFFFF, "ignored_writes");
        ctrl(8'd1, 1, 0);
        v1 = 16'($urandom_range(0, 16'hEEED));
        push_val(v1);
        wait_done("single_done");
        chk_const(A_RES, v1, 16'hFFFF, "single_result");

        for (int it = 0; it < 10; it++) begin
            int room;
            int k;
            int c;
            room = DEPTH - mq.size();
            k = (room > 0) ? int'($urandom_range(0, room)) : 0;
            for (int j = 0; j < k; j++)
                push_val(16'($urandom));
            c = int'($urandom_range(1, mq.size() + 2));
            ctrl(8'(c), 1, 0);
            while (m_run)
                push_val(16'($urandom));
            wait_done("rand_done");
            chk_result_m("rand_result");
            chk_status("rand_status");
        end

        ctrl(8'd0, 0, 1);
        push_val(16'($urandom));
        push_val(16'($urandom));
        ctrl(8'd5, 1, 0);
        repeat (3) @(posedge mclk);
        chk_const(A_STAT, 16'h0309, 16'hFFFF, "midrun_status");
        @(posedge mclk);
        #2;
        puc_rst_n = 1'b0;
        m_reset();
        per_en   = 1'b1;
        per_addr = A_STAT;
        per_we   = 2'b00;
        #1;
        checks++;
        if (per_dout !== 16'h0000) begin
            failures++;
            $display("FAIL dout_in_reset got=%h exp=0000", per_dout);
        end
        per_en = 1'b0;
        repeat (2) @(posedge mclk);
        #1;
        puc_rst_n = 1'b1;
        chk_const(A_STAT, 16'h0008, 16'hFFFF, "post_reset_status");
        chk_const(A_RES, 16'h0000, 16'hFFFF, "post_reset_result");

        repeat (3) @(posedge mclk);
        checks++;
        if (expq.size() != 0) begin
            failures++;
            $display("FAIL leftover_expect got=%0d exp=0", expq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    task automatic chk_result_m(input string nm);
        logic [15:0] v;
        bus_rd(A_RES, m_res, 16'hFFFF, nm, v);
    endtask

endmodule
